// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the register file's single write port.
// ALU writes win every cycle; load returns queue in a small FIFO with WAW kill and hit lookup.
module wb_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alu_valid,
   input  logic [4:0]                alu_addr,
   input  logic [63:0]               alu_data,
   input  logic                      mem_valid,
   input  logic [4:0]                mem_addr,
   input  logic [63:0]               mem_data,
   output logic                      mem_ready,
   output logic                      wr_en,
   output logic [4:0]                wr_addr,
   output logic [63:0]               wr_data,
   input  logic [4:0]                q_addr1,
   input  logic [4:0]                q_addr2,
   output logic                      q_hit1,
   output logic                      q_hit2,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [4:0]  XZR  = 5'd31;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic          live_q [DEPTH];
   logic          live_d [DEPTH];
   logic [4:0]    addr_q [DEPTH];
   logic [63:0]   data_q [DEPTH];

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;

   logic          wr_en_q, wr_en_d;
   logic [4:0]    wr_addr_q, wr_addr_d;
   logic [63:0]   wr_data_q, wr_data_d;

   logic          alu_wr;
   logic          mem_acc;
   logic          push;
   logic          pop;

   assign alu_wr    = alu_valid && (alu_addr != XZR);
   assign mem_ready = !reset && (count_q < FULL);
   assign mem_acc   = mem_valid && mem_ready;
   // A load racing an ALU write to the same register is older, so it is simply dropped.
   assign push      = mem_acc && (mem_addr != XZR) && !(alu_wr && (alu_addr == mem_addr));
   assign pop       = !alu_wr && (count_q != '0);

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         live_d[i] = live_q[i];
         if (alu_wr && (addr_q[i] == alu_addr)) begin
            live_d[i] = 1'b0;
         end
      end
      if (pop) begin
         live_d[rptr_q] = 1'b0;
      end
      if (push) begin
         live_d[wptr_q] = 1'b1;
      end
   end

   always_comb begin
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (alu_wr) begin
         wr_en_d   = 1'b1;
         wr_addr_d = alu_addr;
         wr_data_d = alu_data;
      end else if (pop && live_q[rptr_q]) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_q[rptr_q];
         wr_data_d = data_q[rptr_q];
      end
   end

   always_comb begin
      q_hit1 = 1'b0;
      q_hit2 = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (live_q[i] && (addr_q[i] == q_addr1)) q_hit1 = 1'b1;
         if (live_q[i] && (addr_q[i] == q_addr2)) q_hit2 = 1'b1;
      end
      if (q_addr1 == XZR) q_hit1 = 1'b0;
      if (q_addr2 == XZR) q_hit2 = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            live_q[i] <= 1'b0;
         end
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            live_q[i] <= live_d[i];
         end
      end
   end

   // Payload needs no reset: the live bit alone decides whether a slot means anything.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wptr_q] <= mem_addr;
         data_q[wptr_q] <= mem_data;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign count   = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue model of the load FIFO predicts every write,
// expected writes go through a scoreboard queue and are popped when the write port updates.
module tb_wb_arbiter;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_addr;
   logic [63:0] alu_data;
   logic        mem_valid;
   logic [4:0]  mem_addr;
   logic [63:0] mem_data;
   logic        mem_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [4:0]  q_addr1;
   logic [4:0]  q_addr2;
   logic        q_hit1;
   logic        q_hit2;
   logic [$clog2(DEPTH):0] count;

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .q_addr1   (q_addr1),
      .q_addr2   (q_addr2),
      .q_hit1    (q_hit1),
      .q_hit2    (q_hit2),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        live;
      logic [4:0]  addr;
      logic [63:0] data;
   } ent_t;

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
   } wr_t;

   ent_t        mq[$];
   wr_t         exp_q[$];
   logic [4:0]  last_addr;
   logic [63:0] last_data;
   int          n_checks;
   int          n_fail;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic model_hit(input logic [4:0] a);
      foreach (mq[i]) begin
         if (mq[i].live && mq[i].addr == a && a != 5'd31) return 1'b1;
      end
      return 1'b0;
   endfunction

   // One clock cycle: drive, check combinational outputs, advance the model, check the write port.
   task automatic step(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [63:0] md,
                       input logic [4:0] qa1, input logic [4:0] qa2, output logic acc);
      logic ready;
      logic alu_w;
      logic exp_wr;
      ent_t h;
      wr_t  e;
      alu_valid = av;
      alu_addr  = aa;
      alu_data  = ad;
      mem_valid = mv;
      mem_addr  = ma;
      mem_data  = md;
      q_addr1   = qa1;
      q_addr2   = qa2;
      #1;
      ready = (mq.size() < DEPTH);
      check_eq("mem_ready", 64'(mem_ready), 64'(ready));
      check_eq("count", 64'(count), 64'(mq.size()));
      check_eq("q_hit1", 64'(q_hit1), 64'(model_hit(qa1)));
      check_eq("q_hit2", 64'(q_hit2), 64'(model_hit(qa2)));

      alu_w  = av && (aa != 5'd31);
      exp_wr = 1'b0;
      acc    = 1'b0;
      if (alu_w) begin
         exp_q.push_back('{addr: aa, data: ad});
         exp_wr = 1'b1;
         foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         if (h.live) begin
            exp_q.push_back('{addr: h.addr, data: h.data});
            exp_wr = 1'b1;
         end
      end
      if (mv && ready) begin
         acc = 1'b1;
         if (ma != 5'd31 && !(alu_w && ma == aa)) mq.push_back('{live: 1'b1, addr: ma, data: md});
      end

      @(posedge clk);
      #1;
      if (exp_wr) begin
         e = exp_q.pop_front();
         last_addr = e.addr;
         last_data = e.data;
      end
      check_eq("wr_en", 64'(wr_en), 64'(exp_wr));
      check_eq("wr_addr", 64'(wr_addr), 64'(last_addr));
      check_eq("wr_data", wr_data, last_data);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
   endtask

   initial begin
      logic acc;
      int   sent;
      int   guard;
      n_checks  = 0;
      n_fail    = 0;
      last_addr = '0;
      last_data = '0;
      reset     = 1'b1;
      alu_valid = 1'b0;
      alu_addr  = '0;
      alu_data  = '0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      q_addr1   = '0;
      q_addr2   = '0;

      #12;
      check_eq("rst_wr_en", 64'(wr_en), 64'(0));
      check_eq("rst_wr_addr", 64'(wr_addr), 64'(0));
      check_eq("rst_wr_data", wr_data, 64'(0));
      check_eq("rst_count", 64'(count), 64'(0));
      check_eq("rst_mem_ready", 64'(mem_ready), 64'(0));
      check_eq("rst_q_hit1", 64'(q_hit1), 64'(0));
      check_eq("rst_q_hit2", 64'(q_hit2), 64'(0));
      @(negedge clk);
      reset = 1'b0;

      // ALU only
      step(1, 5, 64'h1234, 0, 0, 0, 0, 0, acc);
      idle(2);

      // Load buffering behind six ALU writes
      for (int i = 0; i < 6; i++) begin
         step(1, 5'(1 + i), 64'h100 + 64'(i), (i < 4), 5'(10 + i), 64'hA000 + 64'(i),
              5'd12, 5'd10, acc);
      end
      check_eq("buf_count_full", 64'(count), 64'(DEPTH));
      idle(5);

      // WAW kill: X8 then X7 queued, ALU writes X7
      step(1, 1, 64'h1, 1, 8, 64'h88, 7, 8, acc);
      step(1, 2, 64'h2, 1, 7, 64'hAA, 7, 8, acc);
      step(1, 7, 64'hBB, 0, 0, 0, 7, 8, acc);
      step(0, 0, 0, 0, 0, 0, 7, 8, acc);
      idle(3);
      // Same-cycle load and ALU write to one register: the load is dropped
      step(1, 9, 64'h99, 1, 9, 64'h9999, 9, 0, acc);
      idle(2);

      // XZR filtering
      step(1, 31, 64'hDEAD, 0, 0, 0, 31, 0, acc);
      step(0, 0, 0, 1, 31, 64'hBEEF, 31, 31, acc);
      idle(2);

      // Full and simultaneous: fill, then offer a load while the head drains
      for (int i = 0; i < 4; i++) step(1, 5'(1 + i), 64'(i), 1, 5'(20 + i), 64'hC0 + 64'(i),
                                       5'd20, 5'd23, acc);
      step(0, 0, 0, 1, 24, 64'hC4, 24, 0, acc);
      check_eq("full_not_accepted", 64'(q_hit1), 64'(0));
      step(0, 0, 0, 1, 24, 64'hC4, 24, 0, acc);
      idle(6);

      // Ten loads with random ALU interference, exercising pointer wrap
      sent  = 0;
      guard = 0;
      while (sent < 10 && guard < 300) begin
         step(($urandom_range(0, 2) != 0), 5'(1 + guard % 3), 64'(guard),
              1, 5'(16 + sent), 64'hD000 + 64'(sent), 5'(16 + sent), 5'd16, acc);
         if (acc) sent++;
         guard++;
      end
      check_eq("ten_loads_sent", 64'(sent), 64'(10));
      idle(8);

      // Reset mid-operation with three queued loads
      for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 64'(i), 1, 5'(12 + i), 64'hE0 + 64'(i),
                                       5'd12, 5'd13, acc);
      check_eq("pre_rst_count", 64'(count), 64'(3));
      #2;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_wr_en", 64'(wr_en), 64'(0));
      check_eq("mid_rst_count", 64'(count), 64'(0));
      check_eq("mid_rst_mem_ready", 64'(mem_ready), 64'(0));
      check_eq("mid_rst_q_hit1", 64'(q_hit1), 64'(0));
      mq.delete();
      exp_q.delete();
      last_addr = '0;
      last_data = '0;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(5);

      if (exp_q.size() != 0) check_eq("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter placed directly upstream of the register file's single write port (we3/wa3/wd3).
- Merges two write sources into one registered write per cycle:
  - the ALU result path, which can never stall;
  - the load-return path from data memory, which is buffered in a small FIFO.
- Provides scoreboard hit outputs so decode can stall reads of registers that still have a queued load.

Parameters:
- DEPTH, 4: FIFO entries for pending load write-backs. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU write request this cycle.
- alu_addr  in  5  ALU destination register.
- alu_data  in  64  ALU result.
- mem_valid  in  1  load return valid.
- mem_addr  in  5  load destination register.
- mem_data  in  64  loaded data.
- mem_ready  out  1  FIFO can accept a load return this cycle.
- wr_en  out  1  to regfile we3.
- wr_addr  out  5  to regfile wa3.
- wr_data  out  64  to regfile wd3.
- q_addr1  in  5  decode read address 1.
- q_addr2  in  5  decode read address 2.
- q_hit1  out  1  a live FIFO entry targets q_addr1.
- q_hit2  out  1  a live FIFO entry targets q_addr2.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, including killed entries.

Behaviour:
- Reset (asynchronous):
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, count=0, q_hit1=q_hit2=0.
  - All FIFO entries are cleared to not live.
  - mem_ready=0 while reset is high.
  - Reset asserted mid-operation discards every queued entry; nothing is written after reset releases.
- mem_ready is combinational: mem_ready = !reset && (count < DEPTH).
  - No accept-when-full, even when a dequeue occurs in the same cycle.
  - A load is accepted when mem_valid && mem_ready.
- Address 31 (XZR) filtering:
  - An ALU request to address 31 is ignored: no write, no kill.
  - An accepted load to address 31 is consumed without being enqueued.
- Write port outputs are registered, with one cycle of latency. The write-port selection at each rising edge is:
  1. If alu_valid and alu_addr≠31: wr_en=1, wr_addr=alu_addr, wr_data=alu_data. The FIFO does not pop.
  2. Else if count>0: pop the head entry.
     - Head live: wr_en=1 with the head's address and data.
     - Head killed: wr_en=0.
  3. Else: wr_en=0. wr_addr and wr_data hold their previous values.
- WAW kill:
  - An accepted ALU write to address A marks every live FIFO entry with address A as killed.
  - A load to address A accepted in that same cycle is treated as older. It is consumed and not enqueued (dropped).
  - Killed entries keep their slot and occupy one drain cycle with wr_en=0.
- FIFO structure:
  - Circular buffer with wrap-around read and write pointers.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Per-entry fields: live bit, 5-bit address, 64-bit data.
- q_hit1 and q_hit2 are combinational.
  - qhitN = 1 if any live entry has address equal to q_addrN, and q_addrN≠31.
  - They do not reflect the write currently on wr_* (the regfile handles that case).
- Ordering: live entries drain in arrival order.
- Starvation: consecutive ALU writes starve the drain indefinitely, by design. Decode is stalled via q_hit.

Test Plan:
- Reset check:
  - Stimulus: assert reset mid-cycle while count=3.
  - Required: wr_en=0, count=0 and mem_ready=0 immediately, without waiting for a clock edge.
  - Required after release: mem_ready=1 and no writes occur.
- ALU only:
  - Stimulus: alu_valid with addr 5, data 0x1234 for one cycle.
  - Required after the next edge: wr_en=1, wr_addr=5, wr_data=0x1234; the following cycle wr_en=0.
- Load buffering:
  - Stimulus: alu_valid for 6 consecutive cycles to X1..X6, while loads arrive to X10..X13 on cycles 1–4.
  - Required: count reaches 4 and mem_ready=0; q_hit1=1 with q_addr1=12.
  - Required after the ALU stops: X10..X13 are written in order on 4 consecutive cycles.
- WAW kill:
  - Stimulus: a load to X7 (data 0xAA) is queued behind a load to X8, then an ALU write to X7 (data 0xBB).
  - Required: X7 is written only with 0xBB; the drain shows X8 written, then one cycle with wr_en=0; q_hit for X7 drops to 0 right after the kill edge.
- XZR:
  - Stimulus: ALU write to addr 31, and separately a load to addr 31.
  - Required: wr_en stays 0, count stays 0, q_hit1=0 for q_addr1=31.
- Full and simultaneous:
  - Stimulus: with count=4, offer mem_valid while the head drains.
  - Required: mem_ready=0 and the load is not accepted; the next cycle count=3, mem_ready=1, and the load is accepted; pointer wrap-around yields correct order over 10 loads.
